// File: rtl/spi_flash_prog.sv
// Program/erase engine for the SPI boot flash: WREN, then sector erase or page
// program, then Read Status polling until WIP clears. SPI mode 0, MSB first.
module spi_flash_prog #(
    parameter int          CKDIV   = 2,
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        C25M,
    input  logic        RES,
    input  logic        Start,
    input  logic        Op,
    input  logic [23:0] Addr,
    input  logic [8:0]  Len,
    input  logic [7:0]  Din,
    input  logic        DinValid,
    output logic        DinReady,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [7:0]  Status,
    output logic        nFCS,
    output logic        FCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic [2:0]  dbgState
);

    typedef enum logic [2:0] {
        IDLE, WREN, GAP1, CMD, DATA, GAP2, POLL, FIN
    } state_t;

    localparam int DW = (CKDIV > 1) ? $clog2(4 * CKDIV) : 2;
    localparam logic [DW-1:0] DIV_LAST = DW'(CKDIV - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(4 * CKDIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    state_t        state, stateN;
    logic          ncs, ncsN;
    logic          fck, fckN;
    logic [31:0]   shReg, shRegN;
    logic [5:0]    bitsLeft, bitsLeftN;
    logic [DW-1:0] divCnt, divCntN;
    logic          tail, tailN;
    logic          opReg, opRegN;
    logic [23:0]   addrReg, addrRegN;
    logic [8:0]    lenReg, lenRegN;
    logic [8:0]    byteCnt, byteCntN;
    logic [7:0]    statReg, statRegN;
    logic [7:0]    rxReg, rxRegN;
    logic [2:0]    rxCnt, rxCntN;
    logic          statusPhase, statusPhaseN;
    logic          pollDone, pollDoneN;
    logic [23:0]   pollCnt, pollCntN;
    logic          errReg, errRegN;
    logic          doneReg, doneRegN;
    logic [9:0]    pageEnd;
    logic          reject;

    // A program must stay inside one 256-byte page, otherwise the flash wraps.
    assign pageEnd = {2'b00, Addr[7:0]} + {1'b0, Len};
    assign reject  = Op && ((Len == 9'd0) || (Len > 9'd256) || (pageEnd > 10'd256));

    // Handshake: a Din byte moves on any rising C25M edge where DinValid and
    // DinReady are both high; DinReady only rises with the shifter empty.
    assign DinReady = (state == DATA) && !tail && (bitsLeft == 6'd0);
    assign Busy     = (state != IDLE);
    assign Done     = doneReg;
    assign Err      = errReg;
    assign Status   = statReg;
    assign nFCS     = ncs;
    assign FCK      = fck;
    assign MOSI     = shReg[31] & ~ncs;
    assign dbgState = state;

    always_ff @(posedge C25M) begin
        if (RES) begin
            state       <= IDLE;
            ncs         <= 1'b1;
            fck         <= 1'b0;
            shReg       <= '0;
            bitsLeft    <= '0;
            divCnt      <= '0;
            tail        <= 1'b0;
            opReg       <= 1'b0;
            addrReg     <= '0;
            lenReg      <= '0;
            byteCnt     <= '0;
            statReg     <= '0;
            rxReg       <= '0;
            rxCnt       <= '0;
            statusPhase <= 1'b0;
            pollDone    <= 1'b0;
            pollCnt     <= '0;
            errReg      <= 1'b0;
            doneReg     <= 1'b0;
        end else begin
            state       <= stateN;
            ncs         <= ncsN;
            fck         <= fckN;
            shReg       <= shRegN;
            bitsLeft    <= bitsLeftN;
            divCnt      <= divCntN;
            tail        <= tailN;
            opReg       <= opRegN;
            addrReg     <= addrRegN;
            lenReg      <= lenRegN;
            byteCnt     <= byteCntN;
            statReg     <= statRegN;
            rxReg       <= rxRegN;
            rxCnt       <= rxCntN;
            statusPhase <= statusPhaseN;
            pollDone    <= pollDoneN;
            pollCnt     <= pollCntN;
            errReg      <= errRegN;
            doneReg     <= doneRegN;
        end
    end

    always_comb begin
        stateN       = state;
        ncsN         = ncs;
        fckN         = fck;
        shRegN       = shReg;
        bitsLeftN    = bitsLeft;
        divCntN      = divCnt;
        tailN        = tail;
        opRegN       = opReg;
        addrRegN     = addrReg;
        lenRegN      = lenReg;
        byteCntN     = byteCnt;
        statRegN     = statReg;
        rxRegN       = rxReg;
        rxCntN       = rxCnt;
        statusPhaseN = statusPhase;
        pollDoneN    = pollDone;
        pollCntN     = pollCnt;
        errRegN      = errReg;
        doneRegN     = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    opRegN   = Op;
                    addrRegN = Addr;
                    lenRegN  = Len;
                    byteCntN = '0;
                    errRegN  = 1'b0;
                    if (reject) begin
                        // Rejected request: Done rises with the single Busy cycle.
                        errRegN  = 1'b1;
                        doneRegN = 1'b1;
                        stateN   = FIN;
                    end else begin
                        stateN    = WREN;
                        ncsN      = 1'b0;
                        fckN      = 1'b0;
                        shRegN    = {8'h06, 24'h0};
                        bitsLeftN = 6'd8;
                        divCntN   = '0;
                        tailN     = 1'b0;
                    end
                end
            end

            GAP1, GAP2: begin
                if (divCnt == GAP_LAST) begin
                    divCntN = '0;
                    ncsN    = 1'b0;
                    if (state == GAP1) begin
                        stateN    = CMD;
                        shRegN    = {(opReg ? 8'h02 : 8'h20), addrReg};
                        bitsLeftN = 6'd32;
                    end else begin
                        stateN       = POLL;
                        shRegN       = {8'h05, 24'h0};
                        bitsLeftN    = 6'd8;
                        statusPhaseN = 1'b0;
                        pollDoneN    = 1'b0;
                        rxCntN       = '0;
                        pollCntN     = '0;
                    end
                end else begin
                    divCntN = divCnt + DIV_ONE;
                end
            end

            WREN, CMD, DATA, POLL: begin
                if (state == POLL) begin
                    pollCntN = pollCnt + 24'd1;
                end
                if ((state == POLL) && (pollCnt == TIMEOUT - 24'd1)) begin
                    errRegN = 1'b1;
                    stateN  = FIN;
                    ncsN    = 1'b1;
                    fckN    = 1'b0;
                    shRegN  = '0;
                    tailN   = 1'b0;
                end else if (tail) begin
                    // Chip-select hold after the final FCK fall of a command.
                    if (divCnt == DIV_LAST) begin
                        ncsN    = 1'b1;
                        tailN   = 1'b0;
                        divCntN = '0;
                        if (state == WREN) begin
                            stateN = GAP1;
                        end else if (state == POLL) begin
                            stateN = FIN;
                        end else begin
                            stateN = GAP2;
                        end
                    end else begin
                        divCntN = divCnt + DIV_ONE;
                    end
                end else if ((state == DATA) && (bitsLeft == 6'd0)) begin
                    if (DinValid) begin
                        shRegN    = {Din, 24'h0};
                        bitsLeftN = 6'd8;
                        divCntN   = '0;
                        byteCntN  = byteCnt + 9'd1;
                    end
                end else if (!fck) begin
                    if (divCnt == DIV_LAST) begin
                        fckN    = 1'b1;
                        divCntN = '0;
                        if (statusPhase) begin
                            rxRegN = {rxReg[6:0], MISO};
                            rxCntN = rxCnt + 3'd1;
                            if (rxCnt == 3'd7) begin
                                statRegN = {rxReg[6:0], MISO};
                                if (!MISO) begin
                                    pollDoneN = 1'b1;
                                end
                            end
                        end
                    end else begin
                        divCntN = divCnt + DIV_ONE;
                    end
                end else begin
                    if (divCnt == DIV_LAST) begin
                        fckN      = 1'b0;
                        divCntN   = '0;
                        shRegN    = {shReg[30:0], 1'b0};
                        bitsLeftN = bitsLeft - 6'd1;
                        if (bitsLeft == 6'd1) begin
                            case (state)
                                WREN: tailN = 1'b1;
                                CMD: begin
                                    if (opReg) begin
                                        stateN = DATA;
                                    end else begin
                                        tailN = 1'b1;
                                    end
                                end
                                DATA: begin
                                    if (byteCnt == lenReg) begin
                                        tailN = 1'b1;
                                    end
                                end
                                default: begin
                                    // Status bytes keep clocking with MOSI low until WIP clears.
                                    if (pollDone) begin
                                        tailN = 1'b1;
                                    end else begin
                                        bitsLeftN    = 6'd8;
                                        statusPhaseN = 1'b1;
                                    end
                                end
                            endcase
                        end
                    end else begin
                        divCntN = divCnt + DIV_ONE;
                    end
                end
            end

            FIN: begin
                stateN   = IDLE;
                ncsN     = 1'b1;
                fckN     = 1'b0;
                shRegN   = '0;
                tailN    = 1'b0;
                // A reject already pulsed Done on entry; a real operation pulses it now.
                doneRegN = !doneReg;
            end

            default: begin
                stateN = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_prog.sv
// Directed bench for spi_flash_prog with a behavioural SPI flash that records
// the command stream and answers Read Status with a scripted WIP sequence.
module tb_spi_flash_prog;

    localparam int CKDIV = 2;

    logic        C25M = 1'b0;
    logic        RES = 1'b1;
    logic        Start = 1'b0;
    logic        Op = 1'b0;
    logic [23:0] Addr = '0;
    logic [8:0]  Len = '0;
    logic [7:0]  Din = '0;
    logic        DinValid = 1'b0;
    logic        DinReady, Busy, Done, Err, nFCS, FCK, MOSI, MISO;
    logic [7:0]  Status;
    logic [2:0]  dbgState;

    spi_flash_prog #(.CKDIV(CKDIV), .TIMEOUT(24'd1000)) dut (
        .C25M(C25M), .RES(RES), .Start(Start), .Op(Op), .Addr(Addr), .Len(Len),
        .Din(Din), .DinValid(DinValid), .DinReady(DinReady), .Busy(Busy),
        .Done(Done), .Err(Err), .Status(Status), .nFCS(nFCS), .FCK(FCK),
        .MOSI(MOSI), .MISO(MISO), .dbgState(dbgState)
    );

    always #20 C25M = ~C25M;

    int vecCount = 0;
    int missCount = 0;
    logic [7:0] exp_q[$];
    logic [7:0] dinQ[$];

    // Flash model: MOSI captured on FCK rise; status bytes driven MSB first.
    logic [7:0] rxq[$];
    logic [7:0] mCur = '0;
    int  mBitIdx = 0;
    bit  mIsPoll = 0;
    int  frameCount = 0;
    int  busyBytes = 0;
    int  sIdx;
    logic [7:0] mStat;
    logic modelMiso;

    always @(negedge nFCS) begin
        mBitIdx = 0;
        mIsPoll = 0;
        mCur = '0;
        frameCount++;
    end

    always @(posedge FCK) begin
        if (!nFCS) begin
            mCur = {mCur[6:0], MOSI};
            mBitIdx++;
            if (mBitIdx % 8 == 0) begin
                if (mBitIdx == 8) begin
                    mIsPoll = (mCur == 8'h05);
                    rxq.push_back(mCur);
                end else if (!mIsPoll) begin
                    rxq.push_back(mCur);
                end
            end
        end
    end

    always_comb begin
        sIdx = (mBitIdx - 8) / 8;
        mStat = (sIdx < busyBytes) ? 8'h03 : 8'h00;
        modelMiso = (!nFCS && mIsPoll && mBitIdx >= 8) ? mStat[3'(7 - (mBitIdx % 8))] : 1'b0;
    end
    assign MISO = modelMiso;

    // Pin timing monitor, sampled just after each rising edge.
    int cyc = 0;
    int lastFallCyc = 0, csFallCyc = 0, csRiseCyc = 0, doneCount = 0, lastDoneCyc = 0;
    bit prevFck = 0, prevNcs = 1, setupPending = 0, haveRise = 0;
    int holdQ[$], gapQ[$], setupQ[$];
    int xferCount = 0;

    always @(posedge C25M) begin
        #1;
        cyc++;
        if (prevFck && !FCK) lastFallCyc = cyc;
        if (!prevFck && FCK && setupPending) begin
            setupQ.push_back(cyc - csFallCyc);
            setupPending = 0;
        end
        if (prevNcs && !nFCS) begin
            if (haveRise) gapQ.push_back(cyc - csRiseCyc);
            csFallCyc = cyc;
            setupPending = 1;
        end
        if (!prevNcs && nFCS) begin
            holdQ.push_back(cyc - lastFallCyc);
            csRiseCyc = cyc;
            haveRise = 1;
        end
        if (Done) begin
            doneCount++;
            lastDoneCyc = cyc;
        end
        prevFck = FCK;
        prevNcs = nFCS;
    end

    always @(negedge C25M) begin
        if (!RES && DinValid && DinReady) xferCount++;
    end

    task automatic tick();
        @(posedge C25M);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecCount++;
        assert (obs === expv) else begin
            missCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic startOp(input logic op, input logic [23:0] a, input logic [8:0] l);
        Op = op;
        Addr = a;
        Len = l;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic clearTrace();
        rxq.delete();
        exp_q.delete();
        holdQ.delete();
        gapQ.delete();
        setupQ.delete();
        haveRise = 0;
        setupPending = 0;
    endtask

    task automatic compareStream(input string tag);
        int n;
        check({tag, "_len"}, rxq.size(), exp_q.size());
        n = (rxq.size() < exp_q.size()) ? rxq.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), rxq[i], exp_q[i]);
    endtask

    task automatic waitDone(input string tag);
        bit got;
        got = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            tick();
            if (Done) got = 1;
        end
        check({tag, "_done"}, got, 1);
        if (got) begin
            check({tag, "_busy_at_done"}, Busy, 1'b0);
            tick();
            check({tag, "_done_width"}, Done, 1'b0);
        end
    endtask

    // Feeds the first count bytes of dinQ; optionally withholds byte stallAt.
    task automatic feed(input int count, input int stallAt, input int stallLen);
        bit got, x, stallBad;
        for (int i = 0; i < count; i++) begin
            if (i == stallAt) begin
                DinValid = 1'b0;
                got = 0;
                for (int c = 0; c < 2000 && !got; c++) begin
                    tick();
                    if (DinReady) got = 1;
                end
                check("stall_reach", got, 1);
                stallBad = 0;
                for (int c = 0; c < stallLen; c++) begin
                    tick();
                    if (FCK !== 1'b0 || nFCS !== 1'b0 || DinReady !== 1'b1) stallBad = 1;
                end
                check("stall_hold", stallBad, 0);
            end
            Din = dinQ[i];
            DinValid = 1'b1;
            got = 0;
            for (int c = 0; c < 2000 && !got; c++) begin
                x = DinReady;
                tick();
                if (x) got = 1;
            end
            if (!got) begin
                check("din_xfer", got, 1);
                DinValid = 1'b0;
                return;
            end
        end
        DinValid = 1'b0;
    endtask

    initial begin
        int f0, d0, x0, dly;

        // Reset state
        repeat (3) tick();
        check("rst_ncs", nFCS, 1'b1);
        check("rst_fck", FCK, 1'b0);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_err", Err, 1'b0);
        check("rst_dinready", DinReady, 1'b0);
        check("rst_status", Status, 8'h00);
        check("rst_state", dbgState, 3'd0);
        RES = 1'b0;
        tick();

        // Sector erase, WIP high for three status bytes
        clearTrace();
        busyBytes = 3;
        f0 = frameCount;
        d0 = doneCount;
        exp_q = '{8'h06, 8'h20, 8'h01, 8'h20, 8'h00, 8'h05};
        startOp(1'b0, 24'h012000, 9'd0);
        tick();
        check("er_first_busy", Busy, 1'b1);
        check("er_first_ncs", nFCS, 1'b0);
        check("er_first_fck", FCK, 1'b0);
        check("er_first_mosi", MOSI, 1'b0);
        waitDone("er");
        compareStream("er");
        check("er_frames", frameCount - f0, 3);
        check("er_done_count", doneCount - d0, 1);
        check("er_err", Err, 1'b0);
        check("er_status", Status, 8'h00);
        check("er_setup", (setupQ.size() > 0) ? setupQ[0] : -1, CKDIV);
        check("er_hold", (holdQ.size() > 0) ? holdQ[0] : -1, CKDIV);
        check("er_gap1", (gapQ.size() > 0) ? gapQ[0] : -1, 4 * CKDIV);

        // Page program, DinValid held high
        clearTrace();
        busyBytes = 1;
        f0 = frameCount;
        x0 = xferCount;
        dinQ = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        exp_q = '{8'h06, 8'h02, 8'h03, 8'h45, 8'h10, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h05};
        startOp(1'b1, 24'h034510, 9'd4);
        feed(4, -1, 0);
        waitDone("pg");
        compareStream("pg");
        check("pg_xfers", xferCount - x0, 4);
        check("pg_frames", frameCount - f0, 3);
        check("pg_err", Err, 1'b0);

        // Same program with a 50-cycle stall before byte 3
        clearTrace();
        x0 = xferCount;
        exp_q = '{8'h06, 8'h02, 8'h03, 8'h45, 8'h10, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h05};
        startOp(1'b1, 24'h034510, 9'd4);
        feed(4, 2, 50);
        waitDone("st");
        compareStream("st");
        check("st_xfers", xferCount - x0, 4);
        check("st_err", Err, 1'b0);

        // Page-crossing and zero-length requests are rejected
        f0 = frameCount;
        startOp(1'b1, 24'h0000F0, 9'd17);
        check("rj17_busy", Busy, 1'b1);
        check("rj17_done", Done, 1'b1);
        check("rj17_err", Err, 1'b1);
        tick();
        check("rj17_busy_after", Busy, 1'b0);
        check("rj17_done_after", Done, 1'b0);
        startOp(1'b1, 24'h000000, 9'd0);
        check("rj0_done", Done, 1'b1);
        check("rj0_err", Err, 1'b1);
        tick();
        check("rj_ncs", nFCS, 1'b1);
        check("rj_frames", frameCount - f0, 0);

        // Last byte of a page is still a legal one-byte program
        clearTrace();
        dinQ = '{8'h3C};
        exp_q = '{8'h06, 8'h02, 8'h00, 8'h00, 8'hFF, 8'h3C, 8'h05};
        startOp(1'b1, 24'h0000FF, 9'd1);
        check("b1_err_cleared", Err, 1'b0);
        feed(1, -1, 0);
        waitDone("b1");
        compareStream("b1");
        check("b1_err", Err, 1'b0);

        // WIP never clears: polling times out
        clearTrace();
        busyBytes = 1000000;
        startOp(1'b0, 24'h0A0000, 9'd0);
        waitDone("to");
        check("to_err", Err, 1'b1);
        check("to_status", Status, 8'h03);
        dly = lastDoneCyc - csFallCyc;
        check("to_delay_window", (dly >= 990 && dly <= 1010) ? 1 : 0, 1);
        busyBytes = 0;
        startOp(1'b0, 24'h0B0000, 9'd0);
        check("to_err_cleared", Err, 1'b0);
        waitDone("to2");
        check("to2_err", Err, 1'b0);

        // Reset in the middle of the second data byte, then a normal erase
        busyBytes = 1;
        d0 = doneCount;
        dinQ = '{8'h11, 8'h22, 8'h33};
        startOp(1'b1, 24'h000100, 9'd3);
        feed(2, -1, 0);
        repeat (6) tick();
        RES = 1'b1;
        tick();
        check("rs_ncs", nFCS, 1'b1);
        check("rs_fck", FCK, 1'b0);
        check("rs_busy", Busy, 1'b0);
        check("rs_done", Done, 1'b0);
        RES = 1'b0;
        tick();
        check("rs_no_done", doneCount - d0, 0);
        clearTrace();
        exp_q = '{8'h06, 8'h20, 8'h05, 8'h60, 8'h00, 8'h05};
        startOp(1'b0, 24'h056000, 9'd0);
        waitDone("rs_er");
        compareStream("rs_er");
        check("rs_er_err", Err, 1'b0);
        check("rs_er_status", Status, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/spi_flash_prog.md
# spi_flash_prog

Program/erase engine for the card's SPI boot flash: the write-side counterpart of the power-up flash loader, which only issues read commands. On request it issues Write Enable (06h), then either Sector Erase (20h, 4 KiB) or Page Program (02h, 1–256 bytes), then polls Read Status (05h) until WIP clears. It sits between the Apple-side register file, which supplies the command, address and data bytes, and the flash pins. Pin ownership muxing with the loader is handled outside this block.

## Interface
- CKDIV, default 2: half-period of FCK in C25M cycles (≥1).
- TIMEOUT, default 24'hFFFFFF: maximum C25M cycles spent in status polling before abort.
- C25M  in  1  system clock, 25 MHz.
- RES  in  1  reset; synchronous, active-high.
- Start  in  1  one-cycle request; sampled only while Busy=0.
- Op  in  1  0 = sector erase (20h), 1 = page program (02h).
- Addr  in  24  flash byte address, latched on Start.
- Len  in  9  program byte count, 1–256, latched on Start; ignored for erase.
- Din  in  8  program data byte.
- DinValid  in  1  Din holds a valid byte.
- DinReady  out  1  engine accepts Din this cycle; a transfer occurs when DinValid and DinReady are both high.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse at the end of an operation.
- Err  out  1  sticky error flag; cleared by the next accepted Start.
- Status  out  8  last status byte read from the flash.
- nFCS  out  1  flash chip select, active-low.
- FCK  out  1  SPI clock, mode 0, idle low.
- MOSI  out  1  serial data to flash, MSB first.
- MISO  in  1  serial data from flash.

## Operation
- States: IDLE, WREN, GAP1, CMD, DATA, GAP2, POLL, FIN.
- IDLE, Start=1: latch Op, Addr, Len; clear Err.
  - Reject when Op=1 and (Len=0, Len>256, or Addr[7:0]+Len>256), i.e. the page would be crossed. Reject means: Err=1, a Done pulse, and no nFCS activity.
  - Otherwise go to WREN.
- WREN: shift out 06h (8 bits), then GAP1.
- GAP1 and GAP2: nFCS high and FCK low for 4·CKDIV cycles.
- CMD: shift out opcode (20h or 02h), then Addr[23:16], Addr[15:8], Addr[7:0] (32 bits).
  - Erase: CMD then GAP2.
  - Program: CMD then DATA.
- DATA: DinReady=1 while the shifter is empty at a byte boundary.
  - While no transfer occurs, FCK holds low and nFCS holds low (stall is legal).
  - After Len bytes have been sent, go to GAP2.
- POLL: shift out 05h, then keep clocking status bytes with MOSI=0.
  - MISO is sampled on each FCK rising edge.
  - At each 8th sampled bit, update Status. If bit0=0, go to FIN.
- TIMEOUT cycles in POLL without WIP clearing: Err=1, go to FIN.
- FIN: nFCS high, FCK low, one-cycle Done pulse, then IDLE.
- Start while Busy=1: ignored.

## Timing
- Reset values: nFCS=1, FCK=0, MOSI=0, Busy=0, Done=0, Err=0, DinReady=0, Status=00h, state IDLE.
- RES mid-operation: outputs take reset values on the next edge, with no Done. A partially programmed page is acceptable.
- Start sampled on edge N:
  - Edge N+1: Busy=1, nFCS=0, MOSI = 06h bit7, FCK=0.
  - Each bit: FCK low for CKDIV cycles, then high for CKDIV cycles.
  - MOSI changes only on FCK falling edges (or on CS assertion for bit7).
- nFCS rises CKDIV cycles after the final FCK fall of a command, and falls CKDIV cycles before its first FCK rise.
- Din transfer on edge M: Din bit7 appears on MOSI at edge M+1. The next DinReady comes no earlier than 8 bit periods later.
- Done and Busy=0 occur on the same edge. Start is accepted again the following cycle.
- Rejected Start: Busy=1 for exactly one cycle, coinciding with Done.
- Bit period = 2·CKDIV cycles. Page program of L bytes with zero stall, CKDIV=2:
  - 8 + 32 + 8·L bits of shifting.
  - Plus GAP1, GAP2 and the chip-select setup/hold cycles.
  - Plus polling.

## Test plan
- Erase, Addr=012000h, flash model WIP=1 for 3 status bytes then 0:
  - MOSI stream 06h | 20h 01h 20h 00h | 05h.
  - Exactly three nFCS low periods.
  - Done pulse, Err=0, Status=00h.
- Program, Addr=034510h, Len=4, Din A5h 5Ah 00h FFh, DinValid always high:
  - Stream 02h 03h 45h 10h A5h 5Ah 00h FFh.
  - Four DinReady transfers.
  - Done with Err=0.
- Same program with DinValid low for 50 cycles before byte 3: FCK and nFCS held low during the stall; byte order and values unchanged.
- Program with Addr[7:0]=F0h, Len=17, and separately Len=0: Err=1, Done pulse, nFCS stays high throughout.
- Erase with a model that keeps WIP=1 and TIMEOUT=1000:
  - Done about 1000 cycles after POLL entry, Err=1.
  - Next Start clears Err.
- RES asserted mid-DATA on byte 2: next edge nFCS=1, FCK=0, Busy=0, no Done. A following erase runs normally.
